// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - UART framed-image loader into imem; checksum option via `UART_IMEM_LOADER_CKSUM_EN
module uart_imem_loader #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int IMEM_AW     = 11
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_boot_mode,
    input  logic               i_uart_rx,
    output logic               o_imem_wren,
    output logic [IMEM_AW-1:0] o_imem_waddr,
    output logic [31:0]        o_imem_wdata,
    output logic               o_core_rst_n,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0] CAPACITY = 17'(1) << IMEM_AW;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
`ifdef UART_IMEM_LOADER_CKSUM_EN
        ST_CKSUM  = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

`ifdef UART_IMEM_LOADER_CKSUM_EN
    localparam state_t ST_FINISH = ST_CKSUM;
`else
    localparam state_t ST_FINISH = ST_DONE;
`endif

    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_active;
    logic [3:0]    rx_bit;
    logic [TW-1:0] rx_timer;
    logic [7:0]    rx_shift;
    logic          byte_vld, frame_err;

    // rx_bit: 0 = start-bit qualification, 1..8 = data bits, 9 = stop bit
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_active <= 1'b0;
            rx_bit    <= 4'd0;
            rx_timer  <= '0;
            rx_shift  <= 8'h00;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1     <= i_uart_rx;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (!rx_active) begin
                if (rx_prev && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_bit    <= 4'd0;
                    rx_timer  <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_timer == HALF_LAST) begin
                    rx_timer <= '0;
                    if (rx_s2) rx_active <= 1'b0;
                    else       rx_bit    <= 4'd1;
                end else begin
                    rx_timer <= rx_timer + 1'b1;
                end
            end else if (rx_timer == BIT_LAST) begin
                rx_timer <= '0;
                if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                    byte_vld  <= rx_s2;
                    frame_err <= !rx_s2;
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 4'd1;
                end
            end else begin
                rx_timer <= rx_timer + 1'b1;
            end
        end
    end

    state_t      state, state_next;
    logic [7:0]  count_lo;
    logic [15:0] count, word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [15:0] len_full;
    logic        last_word;
`ifdef UART_IMEM_LOADER_CKSUM_EN
    logic [7:0]  sum;
`endif

    assign len_full  = {rx_shift, count_lo};
    assign last_word = (word_idx == count - 16'd1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (byte_vld && rx_shift == 8'hA5) state_next = ST_LEN_LO;
            ST_LEN_LO: begin
                if (frame_err)     state_next = ST_ERR;
                else if (byte_vld) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (frame_err) state_next = ST_ERR;
                else if (byte_vld) begin
                    if (len_full == 16'd0)                state_next = ST_FINISH;
                    else if ({1'b0, len_full} > CAPACITY) state_next = ST_ERR;
                    else                                  state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (frame_err) state_next = ST_ERR;
                else if (byte_vld && byte_idx == 2'd3 && last_word) state_next = ST_FINISH;
            end
`ifdef UART_IMEM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (frame_err)     state_next = ST_ERR;
                else if (byte_vld) state_next = (rx_shift == sum) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_next = state;
        endcase
    end

    always_comb begin
        o_busy = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA)
`ifdef UART_IMEM_LOADER_CKSUM_EN
                 || (state == ST_CKSUM)
`endif
                 ;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count_lo     <= 8'h00;
            count        <= 16'h0000;
            word_idx     <= 16'h0000;
            byte_idx     <= 2'd0;
            word_buf     <= 24'h000000;
`ifdef UART_IMEM_LOADER_CKSUM_EN
            sum          <= 8'h00;
`endif
            o_imem_wren  <= 1'b0;
            o_imem_waddr <= '0;
            o_imem_wdata <= 32'h0000_0000;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_core_rst_n <= 1'b0;
        end else begin
            o_imem_wren  <= 1'b0;
            o_done       <= o_done | (state_next == ST_DONE);
            o_err        <= o_err | (state_next == ST_ERR);
            // Core runs freely in non-boot mode; otherwise only once the image is complete
            o_core_rst_n <= !i_boot_mode || (state == ST_DONE);
            if (byte_vld) begin
                case (state)
                    ST_LEN_LO: count_lo <= rx_shift;
                    ST_LEN_HI: count    <= len_full;
                    ST_DATA: begin
`ifdef UART_IMEM_LOADER_CKSUM_EN
                        sum <= sum + rx_shift;
`endif
                        if (byte_idx == 2'd3) begin
                            o_imem_wren  <= 1'b1;
                            o_imem_waddr <= word_idx[IMEM_AW-1:0];
                            o_imem_wdata <= {rx_shift, word_buf};
                            word_idx     <= word_idx + 16'd1;
                            byte_idx     <= 2'd0;
                        end else begin
                            case (byte_idx)
                                2'd0:    word_buf[7:0]   <= rx_shift;
                                2'd1:    word_buf[15:8]  <= rx_shift;
                                default: word_buf[23:16] <= rx_shift;
                            endcase
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
